game_round_controller: RTL

GAME_ROUND_CONTROLLER -- requirements
Module: game_round_controller

---
 rtl/game_round_controller.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/game_round_controller.sv
// game_round_controller
// Round/score/lives controller for a "hole in the wall" style game. A wall
// approaches the player one depth step every frames_per_tick frames. When the
// wall reaches its last depth the round ends, the score grows by the remaining
// lives and the game speeds up. Enough person/wall collision pixels while the
// wall is in the goal depth window costs a life, followed by a short pause.
//
// Ports
//   clk_in, rst_in          : clock, synchronous active-low reset
//   start_in                : start / restart level (honoured in IDLE and GAME_OVER)
//   hcount_in, vcount_in,
//   data_valid_in           : pixel position and valid strobe
//   is_person_in, is_wall_in: person mask and wall mask for the current pixel
//   player_depth_in         : player depth, passed through the pixel pipeline
//   hcount_out .. player_depth_out : pixel path, one register stage
//   wall_depth_out          : current wall depth
//   wall_idx_out            : selects the external wall mask
//   round_out, score_out, lives_out, frames_per_tick_out : game status
//   game_state              : 0 IDLE, 1 PLAYING, 2 HIT_PAUSE, 3 GAME_OVER
module game_round_controller #(
    parameter int SCREEN_WIDTH        = 1280,
    parameter int SCREEN_HEIGHT       = 720,
    parameter int GOAL_DEPTH          = 60,
    parameter int GOAL_DEPTH_DELTA    = 10,
    parameter int MAX_WALL_DEPTH      = 75,
    parameter int MAX_FRAMES_PER_TICK = 15,
    parameter int MIN_FRAMES_PER_TICK = 3,
    parameter int NUM_WALLS           = 10,
    parameter int NUM_LIVES           = 3,
    parameter int HIT_PIXEL_THRESHOLD = 64,
    parameter int PAUSE_FRAMES        = 60,
    localparam int WIDX_W  = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1,
    localparam int LIVES_W = $clog2(NUM_LIVES + 1),
    localparam int FPT_W   = $clog2(MAX_FRAMES_PER_TICK + 1)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start_in,
    input  logic [10:0]        hcount_in,
    input  logic [9:0]         vcount_in,
    input  logic               data_valid_in,
    input  logic               is_person_in,
    input  logic               is_wall_in,
    input  logic [7:0]         player_depth_in,
    output logic [10:0]        hcount_out,
    output logic [9:0]         vcount_out,
    output logic               data_valid_out,
    output logic               is_wall_out,
    output logic               is_person_out,
    output logic               is_collision_out,
    output logic [7:0]         wall_depth_out,
    output logic [7:0]         player_depth_out,
    output logic [WIDX_W-1:0]  wall_idx_out,
    output logic [7:0]         round_out,
    output logic [15:0]        score_out,
    output logic [LIVES_W-1:0] lives_out,
    output logic [FPT_W-1:0]   frames_per_tick_out,
    output logic [1:0]         game_state
);

    localparam int PAUSE_W = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
    localparam int WIN_LO  = GOAL_DEPTH - GOAL_DEPTH_DELTA;
    localparam int WIN_HI  = GOAL_DEPTH + GOAL_DEPTH_DELTA;
    localparam logic [15:0] HIT_TH = 16'(HIT_PIXEL_THRESHOLD);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_HIT_PAUSE = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           depth_q, depth_d;
    logic [FPT_W-1:0]     tick_q, tick_d;
    logic [FPT_W-1:0]     fpt_q, fpt_d;
    logic [WIDX_W-1:0]    idx_q, idx_d;
    logic [7:0]           round_q, round_d;
    logic [15:0]          score_q, score_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [15:0]          hit_cnt_q, hit_cnt_d;
    logic [PAUSE_W-1:0]   pause_q, pause_d;

    logic [10:0]          hcount_q;
    logic [9:0]           vcount_q;
    logic                 valid_q, wall_q, person_q, coll_q;
    logic [7:0]           pdepth_q;

    // Frame and game events derived from the current pixel and state
    logic                 new_frame, in_window, hit_pixel, hit_now, step, pause_done, start_game;
    logic [15:0]          hit_total;
    logic [WIDX_W-1:0]    idx_next;
    logic [16:0]          score_sum;

    assign new_frame  = data_valid_in && (hcount_in == 11'(SCREEN_WIDTH - 1))
                        && (vcount_in == 10'(SCREEN_HEIGHT - 1));
    assign in_window  = ($signed({24'd0, depth_q}) >= WIN_LO) && ($signed({24'd0, depth_q}) <= WIN_HI);
    assign hit_pixel  = (state_q == ST_PLAYING) && data_valid_in && is_person_in && is_wall_in && in_window;
    // The frame's final pixel is folded in before the threshold test
    assign hit_total  = (hit_pixel && (hit_cnt_q != 16'hFFFF)) ? hit_cnt_q + 16'd1 : hit_cnt_q;
    assign hit_now    = hit_total >= HIT_TH;
    assign step       = (tick_q == fpt_q - FPT_W'(1));
    assign pause_done = (pause_q == PAUSE_W'(PAUSE_FRAMES - 1));
    assign start_game = start_in && ((state_q == ST_IDLE) || (state_q == ST_GAME_OVER));
    assign idx_next   = (idx_q == WIDX_W'(NUM_WALLS - 1)) ? '0 : idx_q + WIDX_W'(1);
    assign score_sum  = {1'b0, score_q} + 17'(lives_q);

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a hit on the last life ends the game
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start_in) state_d = ST_PLAYING;
            ST_PLAYING:   if (new_frame && hit_now)
                              state_d = (lives_q == LIVES_W'(1)) ? ST_GAME_OVER : ST_HIT_PAUSE;
            ST_HIT_PAUSE: if (new_frame && pause_done) state_d = ST_PLAYING;
            ST_GAME_OVER: if (start_in) state_d = ST_PLAYING;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Game datapath next values; a hit outranks a coinciding round completion
    always_comb begin
        depth_d   = depth_q;
        tick_d    = tick_q;
        fpt_d     = fpt_q;
        idx_d     = idx_q;
        round_d   = round_q;
        score_d   = score_q;
        lives_d   = lives_q;
        pause_d   = pause_q;
        hit_cnt_d = '0;
        if (start_game) begin
            depth_d = '0;
            tick_d  = '0;
            fpt_d   = FPT_W'(MAX_FRAMES_PER_TICK);
            idx_d   = '0;
            round_d = '0;
            score_d = '0;
            lives_d = LIVES_W'(NUM_LIVES);
            pause_d = '0;
        end else if (state_q == ST_IDLE) begin
            depth_d = '0;
        end else if (state_q == ST_PLAYING) begin
            hit_cnt_d = new_frame ? 16'd0 : hit_total;
            if (new_frame) begin
                if (hit_now) begin
                    lives_d = lives_q - LIVES_W'(1);
                    depth_d = '0;
                    tick_d  = '0;
                    idx_d   = idx_next;
                    pause_d = '0;
                end else if (step) begin
                    tick_d = '0;
                    if (depth_q == 8'(MAX_WALL_DEPTH - 1)) begin
                        depth_d = '0;
                        idx_d   = idx_next;
                        round_d = (round_q == 8'hFF) ? round_q : round_q + 8'd1;
                        score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                        fpt_d   = (fpt_q > FPT_W'(MIN_FRAMES_PER_TICK)) ? fpt_q - FPT_W'(1) : fpt_q;
                    end else begin
                        depth_d = depth_q + 8'd1;
                    end
                end else begin
                    tick_d = tick_q + FPT_W'(1);
                end
            end
        end else if (state_q == ST_HIT_PAUSE) begin
            if (new_frame) begin
                if (pause_done) begin
                    pause_d = '0;
                    depth_d = '0;
                end else begin
                    pause_d = pause_q + PAUSE_W'(1);
                end
            end
        end
    end

    // Datapath and pixel pipeline registers
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            depth_q   <= '0;
            tick_q    <= '0;
            fpt_q     <= FPT_W'(MAX_FRAMES_PER_TICK);
            idx_q     <= '0;
            round_q   <= '0;
            score_q   <= '0;
            lives_q   <= LIVES_W'(NUM_LIVES);
            hit_cnt_q <= '0;
            pause_q   <= '0;
            hcount_q  <= '0;
            vcount_q  <= '0;
            valid_q   <= 1'b0;
            wall_q    <= 1'b0;
            person_q  <= 1'b0;
            coll_q    <= 1'b0;
            pdepth_q  <= '0;
        end else begin
            depth_q   <= depth_d;
            tick_q    <= tick_d;
            fpt_q     <= fpt_d;
            idx_q     <= idx_d;
            round_q   <= round_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            hit_cnt_q <= hit_cnt_d;
            pause_q   <= pause_d;
            hcount_q  <= hcount_in;
            vcount_q  <= vcount_in;
            valid_q   <= data_valid_in;
            wall_q    <= is_wall_in;
            person_q  <= is_person_in;
            coll_q    <= is_person_in && is_wall_in;
            pdepth_q  <= player_depth_in;
        end
    end

    // Outputs are straight register taps
    always_comb begin
        game_state          = state_q;
        wall_depth_out      = depth_q;
        wall_idx_out        = idx_q;
        round_out           = round_q;
        score_out           = score_q;
        lives_out           = lives_q;
        frames_per_tick_out = fpt_q;
        hcount_out          = hcount_q;
        vcount_out          = vcount_q;
        data_valid_out      = valid_q;
        is_wall_out         = wall_q;
        is_person_out       = person_q;
        is_collision_out    = coll_q;
        player_depth_out    = pdepth_q;
    end

endmodule
